// File: rtl/blur_frame_sequencer.sv
// Frame-level sequencer for the RGB444 blur filter: latches the kernel mode per frame,
// tracks pixel position, flags border pixels and re-times SOP/EOP to the filter output.
module blur_frame_sequencer #(
    parameter int IMG_W    = 320,
    parameter int IMG_H    = 240,
    parameter int PIPE_LAT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] mode_req,
    input  logic       valid_in,
    input  logic       ready_in,
    input  logic       sop_in,
    input  logic       eop_in,
    output logic [2:0] mode_active,
    output logic [8:0] col,
    output logic [7:0] row,
    output logic       border_out,
    output logic       sop_out,
    output logic       eop_out,
    output logic       frame_err,
    output logic       busy
);
    localparam int         CW       = $clog2(PIPE_LAT + 1);
    localparam logic [8:0] COL_LAST = 9'(IMG_W - 1);
    localparam logic [7:0] ROW_LAST = 8'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    state_t        state;
    logic [CW-1:0] drain_cnt;
    logic          overrun;
    logic          err_prev;
    logic [2:0]    dly [0:PIPE_LAT-2];

    logic       beat, sop_beat, eop_beat, in_active;
    logic       at_last, pos_last, border_pos, err_now;
    logic [2:0] mode_clamp, mode_nxt, ev, tap;
    logic [8:0] next_col, pos_col;
    logic [7:0] next_row, pos_row;

    assign beat       = valid_in & ready_in;
    assign sop_beat   = beat & sop_in;
    assign eop_beat   = beat & eop_in & ~sop_in;
    assign in_active  = (state == ACTIVE);
    assign mode_clamp = (mode_req > 3'd2) ? 3'd0 : mode_req;
    assign mode_nxt   = sop_beat ? mode_clamp : mode_active;

    // Row saturates on the last line so an overlong frame keeps wrapping columns only.
    assign at_last  = (col == COL_LAST) && (row == ROW_LAST);
    assign next_col = (col == COL_LAST) ? 9'd0 : col + 9'd1;
    assign next_row = (col != COL_LAST) ? row : ((row == ROW_LAST) ? row : row + 8'd1);
    assign pos_col  = sop_beat ? 9'd0 : next_col;
    assign pos_row  = sop_beat ? 8'd0 : next_row;
    assign pos_last = (pos_col == COL_LAST) && (pos_row == ROW_LAST);

    always_comb begin
        border_pos = 1'b0;
        case (mode_nxt)
            3'd1:    border_pos = (pos_row < 8'd2) || (pos_col < 9'd2);
            3'd2:    border_pos = (pos_row < 8'd4) || (pos_col < 9'd4);
            default: border_pos = 1'b0;
        endcase
    end

    assign ev = (sop_beat || (in_active && beat))
              ? {sop_beat, in_active & eop_beat, border_pos} : 3'b000;

    assign err_now = (beat & sop_in & eop_in)
                   | (in_active & sop_beat)
                   | (in_active & eop_beat & ~pos_last)
                   | (in_active & beat & ~sop_in & ~eop_in & (at_last | overrun));

    // Mode 0 bypasses the shift stages; the tap follows the mode the current beat belongs to.
    assign tap = (mode_nxt == 3'd0) ? ev : dly[PIPE_LAT-2];

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            mode_active <= 3'd0;
            col         <= 9'd0;
            row         <= 8'd0;
            drain_cnt   <= '0;
            overrun     <= 1'b0;
            err_prev    <= 1'b0;
            frame_err   <= 1'b0;
            busy        <= 1'b0;
            sop_out     <= 1'b0;
            eop_out     <= 1'b0;
            border_out  <= 1'b0;
            for (int i = 0; i < PIPE_LAT - 1; i++) dly[i] <= 3'b000;
        end else begin
            err_prev  <= err_now;
            frame_err <= err_now & ~err_prev;

            dly[0] <= ev;
            for (int i = 1; i < PIPE_LAT - 1; i++) dly[i] <= dly[i-1];
            {sop_out, eop_out, border_out} <= tap;

            if (sop_beat) begin
                state       <= ACTIVE;
                busy        <= 1'b1;
                mode_active <= mode_clamp;
                col         <= 9'd0;
                row         <= 8'd0;
                overrun     <= 1'b0;
            end else begin
                case (state)
                    ACTIVE: begin
                        if (beat) begin
                            col <= next_col;
                            row <= next_row;
                            if (at_last) overrun <= 1'b1;
                        end
                        if (eop_beat) begin
                            state     <= DRAIN;
                            drain_cnt <= (mode_active == 3'd0) ? '0 : CW'(PIPE_LAT - 1);
                        end
                    end
                    DRAIN: begin
                        if (drain_cnt == '0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            drain_cnt <= drain_cnt - 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_blur_frame_sequencer.sv
// Self-checking bench: delayed SOP/EOP/border events go through a due-cycle scoreboard,
// mode latching/drain length comes from a vector table, frame corner cases are hand sequences.
`timescale 1ns/1ps
module tb_blur_frame_sequencer;
    localparam int W        = 128;
    localparam int H        = 64;
    localparam int PIPE_LAT = 4;
    localparam int LAST     = W * H - 1;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] mode_req;
    logic       valid_in, ready_in, sop_in, eop_in;
    logic [2:0] mode_active;
    logic [8:0] col;
    logic [7:0] row;
    logic       border_out, sop_out, eop_out, frame_err, busy;

    typedef struct {
        int       due;
        bit [2:0] bits;
    } ev_t;

    typedef struct {
        logic [2:0] req;
        int         exp_mode;
        int         lat;
    } vec_t;

    ev_t sb[$];
    int  cyc = 0;
    int  passed = 0;
    int  total = 0;
    int  err_seen = 0;
    int  exp_mode = 0;

    blur_frame_sequencer #(.IMG_W(W), .IMG_H(H), .PIPE_LAT(PIPE_LAT)) dut (
        .clk(clk), .reset(reset), .mode_req(mode_req),
        .valid_in(valid_in), .ready_in(ready_in), .sop_in(sop_in), .eop_in(eop_in),
        .mode_active(mode_active), .col(col), .row(row),
        .border_out(border_out), .sop_out(sop_out), .eop_out(eop_out),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual == expected) passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    endtask

    // Every cycle: whatever the DUT emits on the delayed taps must match the event due now.
    always @(negedge clk) begin
        int exp_bits;
        int act_bits;
        exp_bits = 0;
        if (sb.size() > 0 && sb[0].due < cyc) begin
            checkOutput("missed_event_due", sb[0].due, cyc);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            exp_bits = int'(sb[0].bits);
            void'(sb.pop_front());
        end
        act_bits = int'({sop_out, eop_out, border_out});
        if (exp_bits != 0 || act_bits != 0) checkOutput("sop_eop_border", act_bits, exp_bits);
        if (frame_err) err_seen++;
    end

    function automatic bit borderOf(input int mode, input int x, input int y);
        return (y < 2 * mode) || (x < 2 * mode);
    endfunction

    task automatic applyStimulus(input logic s, input logic e, input int ex, input int ey);
        ev_t ev;
        int  lat;
        if (s) exp_mode = (mode_req > 3'd2) ? 0 : int'(mode_req);
        lat     = (exp_mode == 0) ? 1 : PIPE_LAT;
        ev.bits = {s, e & ~s, borderOf(exp_mode, ex, ey)};
        ev.due  = cyc + lat;
        if (ev.bits != 3'b000) sb.push_back(ev);
        valid_in = 1'b1; ready_in = 1'b1; sop_in = s; eop_in = e;
        @(posedge clk); #1;
        checkOutput("col", int'(col), ex);
        checkOutput("row", int'(row), ey);
        valid_in = 1'b0; sop_in = 1'b0; eop_in = 1'b0;
    endtask

    task automatic gapCycle(input logic v, input logic r, input logic s, input logic e);
        valid_in = v; ready_in = r; sop_in = s; eop_in = e;
        @(posedge clk); #1;
        valid_in = 1'b0; ready_in = 1'b1; sop_in = 1'b0; eop_in = 1'b0;
    endtask

    // Pixels a..b in raster order, with non-beat cycles (markers asserted) sprinkled in.
    task automatic sendRange(input int a, input int b, input logic sf, input logic el);
        for (int i = a; i <= b; i++) begin
            if (i > a && (i % 37) == 36) begin
                if (((i / 37) % 2) == 0) gapCycle(1'b1, 1'b0, 1'b1, 1'b1);
                else                     gapCycle(1'b0, 1'b1, 1'b1, 1'b1);
                checkOutput("hold_col", int'(col), (i - 1) % W);
                checkOutput("hold_row", int'(row), (i - 1) / W);
            end
            applyStimulus(sf && i == a, el && i == b, i % W, i / W);
        end
    endtask

    // Called right after the eop beat: busy stays up for lat cycles, then drops.
    task automatic checkDrain(input int lat);
        repeat (lat - 1) gapCycle(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("busy_in_drain", int'(busy), 1);
        gapCycle(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("busy_after_drain", int'(busy), 0);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) gapCycle(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   e0;

        vecs[0] = '{req: 3'd0, exp_mode: 0, lat: 1};
        vecs[1] = '{req: 3'd1, exp_mode: 1, lat: PIPE_LAT};
        vecs[2] = '{req: 3'd2, exp_mode: 2, lat: PIPE_LAT};
        vecs[3] = '{req: 3'd3, exp_mode: 0, lat: 1};
        vecs[4] = '{req: 3'd7, exp_mode: 0, lat: 1};
        vecs[5] = '{req: 3'd5, exp_mode: 0, lat: 1};

        reset = 1'b1; mode_req = 3'd2;
        valid_in = 1'b0; ready_in = 1'b1; sop_in = 1'b0; eop_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_mode_active", int'(mode_active), 0);
        checkOutput("rst_col", int'(col), 0);
        checkOutput("rst_row", int'(row), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_frame_err", int'(frame_err), 0);
        checkOutput("rst_taps", int'({sop_out, eop_out, border_out}), 0);
        reset = 1'b0;
        idleCycles(2);

        $display("[TB] clean mode-2 frame");
        e0 = err_seen;
        mode_req = 3'd2;
        sendRange(0, LAST, 1'b1, 1'b1);
        checkDrain(PIPE_LAT);
        checkOutput("clean_frame_err", err_seen - e0, 0);
        idleCycles(6);

        $display("[TB] mode table with early eop at (1,0)");
        for (int v = 0; v < 6; v++) begin
            e0 = err_seen;
            mode_req = vecs[v].req;
            applyStimulus(1'b1, 1'b0, 0, 0);
            checkOutput("tbl_mode_active", int'(mode_active), vecs[v].exp_mode);
            checkOutput("tbl_busy", int'(busy), 1);
            applyStimulus(1'b0, 1'b1, 1, 0);
            checkDrain(vecs[v].lat);
            checkOutput("tbl_early_eop_err", err_seen - e0, 1);
            idleCycles(6);
        end

        $display("[TB] mode_req change mid-frame, then early eop at (10,0)");
        e0 = err_seen;
        mode_req = 3'd1;
        sendRange(0, 50 * W + 100, 1'b1, 1'b0);
        mode_req = 3'd2;
        checkOutput("midframe_mode_held", int'(mode_active), 1);
        sendRange(50 * W + 101, LAST, 1'b0, 1'b1);
        checkOutput("endframe_mode_held", int'(mode_active), 1);
        checkDrain(PIPE_LAT);
        checkOutput("modechg_frame_err", err_seen - e0, 0);
        idleCycles(6);
        applyStimulus(1'b1, 1'b0, 0, 0);
        checkOutput("new_mode_latched", int'(mode_active), 2);
        sendRange(1, 10, 1'b0, 1'b1);
        checkDrain(PIPE_LAT);
        checkOutput("early_eop_err", err_seen - e0, 1);
        idleCycles(6);

        $display("[TB] sop at (5,5) mid-frame");
        e0 = err_seen;
        mode_req = 3'd1;
        sendRange(0, 5 * W + 4, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 0, 0);
        checkOutput("restart_busy", int'(busy), 1);
        sendRange(1, LAST, 1'b0, 1'b1);
        checkDrain(PIPE_LAT);
        checkOutput("restart_err", err_seen - e0, 1);
        idleCycles(6);

        $display("[TB] mode_req=7 frame with overrun beat");
        e0 = err_seen;
        mode_req = 3'd7;
        sendRange(0, LAST, 1'b1, 1'b0);
        checkOutput("clamp_mode_active", int'(mode_active), 0);
        applyStimulus(1'b0, 1'b0, 0, H - 1);
        applyStimulus(1'b0, 1'b1, 1, H - 1);
        checkDrain(1);
        checkOutput("overrun_single_pulse", err_seen - e0, 1);
        idleCycles(6);

        $display("[TB] reset mid-frame at (100,40)");
        e0 = err_seen;
        mode_req = 3'd2;
        sendRange(0, 40 * W + 100, 1'b1, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        sb.delete();
        reset = 1'b0;
        checkOutput("midrst_busy", int'(busy), 0);
        checkOutput("midrst_mode_active", int'(mode_active), 0);
        checkOutput("midrst_col", int'(col), 0);
        checkOutput("midrst_row", int'(row), 0);
        checkOutput("midrst_taps", int'({sop_out, eop_out, border_out, frame_err}), 0);
        idleCycles(8);
        mode_req = 3'd1;
        sendRange(0, LAST, 1'b1, 1'b1);
        checkDrain(PIPE_LAT);
        checkOutput("post_reset_err", err_seen - e0, 0);
        idleCycles(6);

        checkOutput("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
